// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
// No logic of its own; the nines-complement helper is pure combinational.
package bcd_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam digit_t BCD_MAX = 4'd9;
  localparam digit_t BCD_ADJ = 4'd6;

  function automatic digit_t nines_comp(input digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit plus carry, decimal-adjusted.
// Combinational, zero latency; no handshake.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    s  = t[3:0];
    co = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      s  = t[3:0] + BCD_ADJ;
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// N-digit BCD add/subtract, one digit per clock LSD first; err port only with BCD_INVALID_CHECK_EN.
// Latency: done pulses DIGITS cycles after the start-sampling edge; results hold until next start.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout
`ifdef BCD_INVALID_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          state;
  logic [CW-1:0]   idx;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic            sub_r;
  logic            carry;
  digit_t          bd;
  digit_t          s_dig;
  logic            co;

  // Subtraction is A + nines(B) + ~borrow, so the carry out means "no borrow".
  assign bd = sub_r ? nines_comp(b_sr[3:0]) : b_sr[3:0];

  bcd_digit_add u_digit (
    .a  (a_sr[3:0]),
    .b  (bd),
    .ci (carry),
    .s  (s_dig),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            sub_r <= sub;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
            sum   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum[4*idx +: 4] <= s_dig;
          a_sr  <= a_sr >> 4;
          b_sr  <= b_sr >> 4;
          carry <= co;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout  <= co;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  // Checks the raw operand digits, before any nines-complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (state == CALC && (a_sr[3:0] > BCD_MAX || b_sr[3:0] > BCD_MAX)) begin
      err <= 1'b1;
    end
  end
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: decimal reference model, directed and random operations.
// Define BCD_INVALID_CHECK_EN to also exercise the err port.
module tb_bcd_serial_adder;

  localparam int D    = 4;
  localparam int W    = 4 * D;
  localparam int MODV = 10 ** D;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  wire          busy;
  wire          done;
  wire          cout;
  wire  [W-1:0] sum;
`ifdef BCD_INVALID_CHECK_EN
  wire          err;
`endif

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BCD_INVALID_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic         chk_sum;
    int           acc_cyc;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           n_acc    = 0;
  int           n_done   = 0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic [W-1:0] rs;
  logic         rc;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rnd_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // Decimal reference: plain integer arithmetic modulo 10^D.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, input logic mc, input int c);
    exp_t e;
    int   x = bcd2int(ma);
    int   y = bcd2int(mb);
    int   r;
    if (!ms) begin
      r      = x + y + int'(mc);
      e.cout = (r >= MODV);
      e.sum  = int2bcd(r % MODV);
    end else begin
      r      = x - y - int'(mc);
      e.cout = (r >= 0);
      e.sum  = int2bcd((r + MODV) % MODV);
    end
    e.err     = has_bad(ma) | has_bad(mb);
    e.chk_sum = !e.err;
    e.acc_cyc = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  task automatic chk_b(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%b required=%b", name, act, req);
  endtask

  // Acceptance detector: an op is taken when start is seen at an edge while idle.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && start && !busy) begin
      q.push_back(model(a, b, sub, cin, cyc));
      n_acc++;
    end
  end

  // Monitor: pops one expectation per done pulse.
  initial forever begin
    @(negedge clk);
    if (rst_n && done) begin
      n_done++;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: actual=done with empty queue required=no done");
      end else begin
        mon_e = q.pop_front();
        if (mon_e.chk_sum) chk("sum", sum, mon_e.sum);
        chk_b("cout", cout, mon_e.cout);
        chk("latency", W'(cyc - mon_e.acc_cyc), W'(D));
`ifdef BCD_INVALID_CHECK_EN
        chk_b("err", err, mon_e.err);
`endif
      end
      last_sum  = sum;
      last_cout = cout;
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic ts, input logic tc,
                       output logic [W-1:0] osum, output logic ocout);
    int k;
    int d0;
    @(negedge clk);
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      $display("FAIL idle_timeout: actual=busy required=idle");
    end
    a = ta; b = tb2; sub = ts; cin = tc; start = 1'b1;
    d0 = n_done;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (n_done == d0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (n_done == d0) begin
      n_checks++;
      $display("FAIL done_timeout: actual=no done required=done");
    end
    osum  = last_sum;
    ocout = last_cout;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc0;
    repeat (2) @(negedge clk);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk_b("rst_cout", cout, 1'b0);
`ifdef BCD_INVALID_CHECK_EN
    chk_b("rst_err", err, 1'b0);
`endif
    rst_n = 1'b1;

    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, rs, rc);
    chk("9999+0001_sum", rs, 16'h0000);  chk_b("9999+0001_cout", rc, 1'b1);
    do_op(16'h0999, 16'h0000, 1'b0, 1'b1, rs, rc);
    chk("0999+0000+1_sum", rs, 16'h1000); chk_b("0999+0000+1_cout", rc, 1'b0);
    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, rs, rc);
    chk("1234+5678_sum", rs, 16'h6912);  chk_b("1234+5678_cout", rc, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_sum", sum, 16'h6912);
      chk_b("hold_cout", cout, 1'b0);
    end
    do_op(16'h5000, 16'h1234, 1'b1, 1'b0, rs, rc);
    chk("5000-1234_sum", rs, 16'h3766);  chk_b("5000-1234_cout", rc, 1'b1);
    do_op(16'h1234, 16'h5000, 1'b1, 1'b0, rs, rc);
    chk("1234-5000_sum", rs, 16'h6234);  chk_b("1234-5000_cout", rc, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, rs, rc);
    chk("0000-0000-1_sum", rs, 16'h9999); chk_b("0000-0000-1_cout", rc, 1'b0);

    // start held high with operands changing every cycle
    @(negedge clk);
    acc0  = n_acc;
    start = 1'b1;
    for (int i = 0; i < 19; i++) begin
      a = rnd_bcd(); b = rnd_bcd(); sub = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_accepts", W'(n_acc - acc0), W'(4));
    drain();

    // async reset in the middle of digit 2
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, rs, rc);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_b("midrst_busy", busy, 1'b0);
    chk_b("midrst_done", done, 1'b0);
    chk("midrst_sum", sum, '0);
    chk_b("midrst_cout", cout, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0042, 16'h0058, 1'b0, 1'b0, rs, rc);
    chk("0042+0058_sum", rs, 16'h0100); chk_b("0042+0058_cout", rc, 1'b0);

    for (int i = 0; i < 30; i++)
      do_op(rnd_bcd(), rnd_bcd(), 1'($urandom), 1'($urandom), rs, rc);

`ifdef BCD_INVALID_CHECK_EN
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, rs, rc);
    chk_b("invalid_err_held", err, 1'b1);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, rs, rc);
    chk_b("valid_err_cleared", err, 1'b0);
`endif

    drain();
    chk("queue_empty", W'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
